sprite_compositor: RTL and testbench
====================================

SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

Interface
REQ-001 SHALL expose: Clk  in  1  system pixel clock; all logic on its rising edge.
REQ-002 SHALL expose: Reset_n  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL expose: DrawX, DrawY  in  10 each  current VGA pixel coordinate.
REQ-004 SHALL expose: blank_n_in, hs_in, vs_in  in  1 each  VGA timing for the pixel at DrawX/DrawY.
REQ-005 SHALL expose: ShipX, ShipY, EnemyX, EnemyY, LaserX, LaserY  in  10 each  sprite top-left corners.
REQ-006 SHALL expose: EnemyAlive, LaserActive  in  1 each  sprite enables; ship is always enabled.
REQ-007 SHALL expose: ship_addr  out  11, enemy_addr  out  10, laser_addr  out  10  sprite-ROM read addresses.
REQ-008 SHALL expose: ship_data, enemy_data, laser_data  in  24 each  ROM RGB returned one Clk after the address.
REQ-009 SHALL expose: EnemyHit  in  1  single-cycle pulse when the enemy is struck.
REQ-010 SHALL expose: Red, Green, Blue  out  8 each; blank_n_out, hs_out, vs_out  out  1 each.

Function
REQ-011 Sprite sizes SHALL be ship 40x40, enemy 30x30, laser 14 wide x 70 tall; address = row*W + col.
REQ-012 Hit test SHALL be X <= DrawX <= X+W-1 and Y <= DrawY <= Y+H-1, evaluated in 11 bits so X+W past 1023 never wraps.
REQ-013 Addresses SHALL be combinational from DrawX/DrawY and positions; 0 when pixel is outside the sprite or sprite disabled.
REQ-014 Stage 1 SHALL register the three hit flags and timing inputs, aligned with ROM data.
REQ-015 Stage 2 SHALL register Red/Green/Blue and timing outputs; total latency DrawX/DrawY -> RGB = 2 Clk, timing delayed identically.
REQ-016 Priority SHALL be laser > ship > enemy > background.
REQ-017 ROM value 24'h000000 SHALL be transparent; lower-priority layer shows through.
REQ-018 Background SHALL be 24'h000000.
REQ-019 When delayed blank_n is 0, RGB SHALL be 0 regardless of hits.
REQ-020 Overlap of all three opaque sprites SHALL output laser_data.
REQ-021 Position inputs changing mid-frame SHALL take effect on the next pixel; no frame latching.

Reset
REQ-022 Reset_n low SHALL force RGB=0, blank_n_out=0, hs_out=1, vs_out=1, hit flags=0, flash counter=0.
REQ-023 Reset mid-frame SHALL flush the pipeline; first valid output 2 Clk after release.
REQ-024 Address outputs are combinational and SHALL NOT depend on reset.

Configuration
REQ-025 Macro HIT_FLASH_EN SHALL enable the enemy hit-flash feature.
REQ-026 With HIT_FLASH_EN: EnemyHit loads a 5-bit frame counter with 16; counter decrements on each vs_in falling edge to 0.
REQ-027 With HIT_FLASH_EN: while counter != 0 and counter[1]==1, opaque enemy pixels SHALL output 24'hFFFFFF.
REQ-028 With HIT_FLASH_EN: EnemyHit during an active flash SHALL reload 16; EnemyHit coincident with vs edge SHALL load 16 (load wins).
REQ-029 Without HIT_FLASH_EN: EnemyHit SHALL be ignored, no counter logic generated, enemy drawn from ROM.

Structure
REQ-030 Package galaga_pkg SHALL hold sprite W/H constants, address widths, KEY_COLOR=24'h000000, rgb_t (24-bit typedef).
REQ-031 Sub-module sprite_hit SHALL, parameterized by W/H/address width, compute hit flag and address; instantiated three times.

Verification
REQ-032 Ship at (100,200), DrawX=100,DrawY=200 -> ship_addr=0; DrawX=139,DrawY=239 -> ship_addr=1599; RGB = ROM data 2 Clk later.
REQ-033 Laser (110,210) over ship (100,200), laser pixel opaque -> laser color; laser pixel 24'h000000 -> ship color at same point.
REQ-034 EnemyX=1000, DrawX=5 -> no hit (no wrap); EnemyAlive=0 over enemy area -> enemy_addr=0, background out.
REQ-035 blank_n_in=0 with ship hit -> RGB=0; hs/vs/blank_n delayed exactly 2 Clk.
REQ-036 HIT_FLASH_EN: EnemyHit then 16 vs falling edges -> enemy white on frames with counter[1]=1, normal after frame 16; without macro -> never white.
REQ-037 Reset_n low mid-line for 3 Clk -> RGB=0, vs_out=1 immediately; valid output resumes 2 Clk after release.

Source files
------------

// File: rtl/galaga_pkg.sv
// Shared sprite geometry, ROM address widths and colour types for the
// sprite compositor.
package galaga_pkg;

  localparam int SHIP_W   = 40;
  localparam int SHIP_H   = 40;
  localparam int ENEMY_W  = 30;
  localparam int ENEMY_H  = 30;
  localparam int LASER_W  = 14;
  localparam int LASER_H  = 70;

  localparam int SHIP_AW  = 11;
  localparam int ENEMY_AW = 10;
  localparam int LASER_AW = 10;

  typedef logic [23:0] rgb_t;

  localparam rgb_t KEY_COLOR   = 24'h000000;
  localparam rgb_t FLASH_COLOR = 24'hFFFFFF;

  localparam logic [4:0] FLASH_LOAD = 5'd16;

  function automatic logic is_opaque(input rgb_t c);
    return c != KEY_COLOR;
  endfunction

endpackage

// File: rtl/sprite_hit.sv
// Rectangle hit test and linear ROM address for one sprite at the current
// pixel; purely combinational.
module sprite_hit #(
  parameter int W  = 1,
  parameter int H  = 1,
  parameter int AW = 1
) (
  input  logic [9:0]    i_draw_x,
  input  logic [9:0]    i_draw_y,
  input  logic [9:0]    i_pos_x,
  input  logic [9:0]    i_pos_y,
  input  logic          i_enable,
  output logic          o_hit,
  output logic [AW-1:0] o_addr
);

  logic [10:0]   w_dx, w_dy, w_px, w_py, w_x_end, w_y_end;
  logic [AW-1:0] w_row, w_col;

  // The extra bit keeps X+W-1 from wrapping for sprites near the right edge.
  assign w_dx    = {1'b0, i_draw_x};
  assign w_dy    = {1'b0, i_draw_y};
  assign w_px    = {1'b0, i_pos_x};
  assign w_py    = {1'b0, i_pos_y};
  assign w_x_end = w_px + 11'(W - 1);
  assign w_y_end = w_py + 11'(H - 1);

  assign o_hit = i_enable
              && (w_dx >= w_px) && (w_dx <= w_x_end)
              && (w_dy >= w_py) && (w_dy <= w_y_end);

  assign w_col  = AW'(i_draw_x - i_pos_x);
  assign w_row  = AW'(i_draw_y - i_pos_y);
  assign o_addr = o_hit ? AW'(w_row * AW'(W) + w_col) : '0;

endmodule

// File: rtl/sprite_compositor.sv
// Two-stage sprite compositor: laser > ship > enemy > black background.
// Optional enemy hit-flash is enabled by defining HIT_FLASH_EN.
module sprite_compositor
  import galaga_pkg::*;
(
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic [9:0]          DrawX,
  input  logic [9:0]          DrawY,
  input  logic                blank_n_in,
  input  logic                hs_in,
  input  logic                vs_in,
  input  logic [9:0]          ShipX,
  input  logic [9:0]          ShipY,
  input  logic [9:0]          EnemyX,
  input  logic [9:0]          EnemyY,
  input  logic [9:0]          LaserX,
  input  logic [9:0]          LaserY,
  input  logic                EnemyAlive,
  input  logic                LaserActive,
  output logic [SHIP_AW-1:0]  ship_addr,
  output logic [ENEMY_AW-1:0] enemy_addr,
  output logic [LASER_AW-1:0] laser_addr,
  input  rgb_t                ship_data,
  input  rgb_t                enemy_data,
  input  rgb_t                laser_data,
  input  logic                EnemyHit,
  output logic [7:0]          Red,
  output logic [7:0]          Green,
  output logic [7:0]          Blue,
  output logic                blank_n_out,
  output logic                hs_out,
  output logic                vs_out
);

  logic w_ship_hit, w_enemy_hit, w_laser_hit;
  logic r_ship_hit, r_enemy_hit, r_laser_hit;
  logic r_blank1, r_hs1, r_vs1;
  logic r_blank2, r_hs2, r_vs2;
  logic w_flash;
  rgb_t w_enemy_px, w_rgb, r_rgb;

  sprite_hit #(.W(SHIP_W), .H(SHIP_H), .AW(SHIP_AW)) u_ship (
    .i_draw_x(DrawX), .i_draw_y(DrawY), .i_pos_x(ShipX), .i_pos_y(ShipY),
    .i_enable(1'b1), .o_hit(w_ship_hit), .o_addr(ship_addr)
  );

  sprite_hit #(.W(ENEMY_W), .H(ENEMY_H), .AW(ENEMY_AW)) u_enemy (
    .i_draw_x(DrawX), .i_draw_y(DrawY), .i_pos_x(EnemyX), .i_pos_y(EnemyY),
    .i_enable(EnemyAlive), .o_hit(w_enemy_hit), .o_addr(enemy_addr)
  );

  sprite_hit #(.W(LASER_W), .H(LASER_H), .AW(LASER_AW)) u_laser (
    .i_draw_x(DrawX), .i_draw_y(DrawY), .i_pos_x(LaserX), .i_pos_y(LaserY),
    .i_enable(LaserActive), .o_hit(w_laser_hit), .o_addr(laser_addr)
  );

  // Stage 1: hit flags and timing line up with ROM data returned this cycle.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_ship_hit  <= 1'b0;
      r_enemy_hit <= 1'b0;
      r_laser_hit <= 1'b0;
      r_blank1    <= 1'b0;
      r_hs1       <= 1'b1;
      r_vs1       <= 1'b1;
    end else begin
      r_ship_hit  <= w_ship_hit;
      r_enemy_hit <= w_enemy_hit;
      r_laser_hit <= w_laser_hit;
      r_blank1    <= blank_n_in;
      r_hs1       <= hs_in;
      r_vs1       <= vs_in;
    end
  end

`ifdef HIT_FLASH_EN
  logic [4:0] r_flash_cnt;
  logic       w_vs_fall;

  assign w_vs_fall = r_vs1 & ~vs_in;

  // A new hit always restarts the flash, even on a frame boundary.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                             r_flash_cnt <= '0;
    else if (EnemyHit)                        r_flash_cnt <= FLASH_LOAD;
    else if (w_vs_fall && r_flash_cnt != '0)  r_flash_cnt <= r_flash_cnt - 5'd1;
  end

  assign w_flash = (r_flash_cnt != '0) && r_flash_cnt[1];
`else
  logic w_unused_hit;
  assign w_unused_hit = EnemyHit;
  assign w_flash      = 1'b0;
`endif

  assign w_enemy_px = (w_flash && is_opaque(enemy_data)) ? FLASH_COLOR : enemy_data;

  // NOTE: the default assignment first guarantees no latch on w_rgb.
  always_comb begin
    w_rgb = KEY_COLOR;
    if (r_blank1) begin
      if (r_laser_hit && is_opaque(laser_data))      w_rgb = laser_data;
      else if (r_ship_hit && is_opaque(ship_data))   w_rgb = ship_data;
      else if (r_enemy_hit && is_opaque(enemy_data)) w_rgb = w_enemy_px;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rgb    <= KEY_COLOR;
      r_blank2 <= 1'b0;
      r_hs2    <= 1'b1;
      r_vs2    <= 1'b1;
    end else begin
      r_rgb    <= w_rgb;
      r_blank2 <= r_blank1;
      r_hs2    <= r_hs1;
      r_vs2    <= r_vs1;
    end
  end

  assign Red         = r_rgb[23:16];
  assign Green       = r_rgb[15:8];
  assign Blue        = r_rgb[7:0];
  assign blank_n_out = r_blank2;
  assign hs_out      = r_hs2;
  assign vs_out      = r_vs2;

endmodule

// File: tb/tb_sprite_compositor.sv
// Scoreboard bench for sprite_compositor: directed cases, randomized pixels
// and positions, mid-frame reset and (with HIT_FLASH_EN) the enemy flash.
module tb_sprite_compositor;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [9:0]  DrawX, DrawY, ShipX, ShipY, EnemyX, EnemyY, LaserX, LaserY;
  logic        blank_n_in, hs_in, vs_in, EnemyAlive, LaserActive, EnemyHit;
  logic [10:0] ship_addr;
  logic [9:0]  enemy_addr, laser_addr;
  logic [23:0] ship_data, enemy_data, laser_data;
  logic [7:0]  Red, Green, Blue;
  logic        blank_n_out, hs_out, vs_out;

  sprite_compositor dut (
    .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .blank_n_in(blank_n_in), .hs_in(hs_in), .vs_in(vs_in),
    .ShipX(ShipX), .ShipY(ShipY), .EnemyX(EnemyX), .EnemyY(EnemyY),
    .LaserX(LaserX), .LaserY(LaserY), .EnemyAlive(EnemyAlive),
    .LaserActive(LaserActive), .ship_addr(ship_addr), .enemy_addr(enemy_addr),
    .laser_addr(laser_addr), .ship_data(ship_data), .enemy_data(enemy_data),
    .laser_data(laser_data), .EnemyHit(EnemyHit), .Red(Red), .Green(Green),
    .Blue(Blue), .blank_n_out(blank_n_out), .hs_out(hs_out), .vs_out(vs_out)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int          due;
    logic [23:0] rgb;
    logic        bl, hs, vs;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   fc = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sprite ROM contents: a fixed pattern with every 7th word transparent.
  function automatic logic [23:0] rom_color(input int id, input int a);
    if (a % 7 == 3) return 24'h0;
    return {8'((a * 7 + id * 50) & 255), 8'((a * 13 + id * 17) & 255) | 8'h01,
            8'((a ^ (id * 3)) & 255)};
  endfunction

  always @(posedge Clk) begin
    ship_data  <= rom_color(1, int'(ship_addr));
    enemy_data <= rom_color(2, int'(enemy_addr));
    laser_data <= rom_color(3, int'(laser_addr));
  end

  function automatic bit in_rect(input int x, y, px, py, w, h, input bit en);
    return en && x >= px && x <= px + w - 1 && y >= py && y <= py + h - 1;
  endfunction

  function automatic bit flash_now();
`ifdef HIT_FLASH_EN
    return fc != 0 && (fc & 2) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // Drive one pixel, check addresses, push the pixel's expected output.
  task automatic pix(input int x, y, input bit bl, hs, vs, input bit flash);
    bit sh, eh, lh;
    int sa, ea, la;
    logic [23:0] c, e_col;
    exp_t e;
    DrawX = 10'(x); DrawY = 10'(y);
    blank_n_in = bl; hs_in = hs; vs_in = vs;
    sh = in_rect(x, y, int'(ShipX),  int'(ShipY),  40, 40, 1'b1);
    eh = in_rect(x, y, int'(EnemyX), int'(EnemyY), 30, 30, EnemyAlive);
    lh = in_rect(x, y, int'(LaserX), int'(LaserY), 14, 70, LaserActive);
    sa = sh ? (y - int'(ShipY))  * 40 + (x - int'(ShipX))  : 0;
    ea = eh ? (y - int'(EnemyY)) * 30 + (x - int'(EnemyX)) : 0;
    la = lh ? (y - int'(LaserY)) * 14 + (x - int'(LaserX)) : 0;
    #1;
    check("ship_addr",  32'(ship_addr),  sa);
    check("enemy_addr", 32'(enemy_addr), ea);
    check("laser_addr", 32'(laser_addr), la);
    e_col = rom_color(2, ea);
    if (flash && e_col != 0) e_col = 24'hFFFFFF;
    c = 24'h0;
    if (!bl)                           c = 24'h0;
    else if (lh && rom_color(3, la) != 0) c = rom_color(3, la);
    else if (sh && rom_color(1, sa) != 0) c = rom_color(1, sa);
    else if (eh && e_col != 0)            c = e_col;
    e.due = cyc + 2; e.rgb = c; e.bl = bl; e.hs = hs; e.vs = vs;
    sb.push_back(e);
    @(posedge Clk); #1;
  endtask

  always @(negedge Clk) begin : monitor
    exp_t e;
    if (Reset_n && sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check("rgb",         {8'h0, Red, Green, Blue}, {8'h0, e.rgb});
      check("blank_n_out", 32'(blank_n_out), 32'(e.bl));
      check("hs_out",      32'(hs_out),      32'(e.hs));
      check("vs_out",      32'(vs_out),      32'(e.vs));
    end
  end

  task automatic check_reset_outs(input string tag);
    check({tag, "_rgb"},   {8'h0, Red, Green, Blue}, 32'h0);
    check({tag, "_blank"}, 32'(blank_n_out), 32'h0);
    check({tag, "_hs"},    32'(hs_out), 32'h1);
    check({tag, "_vs"},    32'(vs_out), 32'h1);
  endtask

  task automatic enemy_check();
    pix(305, 302, 1, 1, 1, flash_now());
    pix(303, 300, 1, 1, 1, flash_now());
  endtask

  task automatic frame_edge();
    pix(0, 0, 1, 1, 1, 1'b0);
    pix(0, 0, 1, 1, 0, 1'b0);
    pix(0, 0, 1, 1, 1, 1'b0);
    if (fc > 0) fc--;
  endtask

  task automatic hit_pulse(input bit vs);
    EnemyHit = 1'b1;
    pix(0, 0, 1, 1, vs, 1'b0);
    EnemyHit = 1'b0;
    fc = 16;
    if (!vs) pix(0, 0, 1, 1, 1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1);
  end

  initial begin
    int base;
    Reset_n = 1'b0; EnemyHit = 1'b0;
    DrawX = 0; DrawY = 0; blank_n_in = 1; hs_in = 0; vs_in = 0;
    ShipX = 100; ShipY = 200; EnemyX = 1000; EnemyY = 0;
    LaserX = 110; LaserY = 210; EnemyAlive = 1; LaserActive = 0;
    repeat (2) @(posedge Clk);
    #1;
    check_reset_outs("reset");
    Reset_n = 1'b1;

    pix(100, 200, 1, 1, 1, 0);
    pix(139, 239, 1, 0, 1, 0);
    pix(140, 239, 1, 1, 0, 0);
    LaserActive = 1;
    pix(110, 210, 1, 1, 1, 0);
    pix(113, 210, 1, 1, 1, 0);
    pix(5, 5, 1, 1, 1, 0);
    pix(1010, 5, 1, 1, 1, 0);
    EnemyAlive = 0;
    pix(1010, 5, 1, 1, 1, 0);
    EnemyAlive = 1;
    pix(120, 220, 0, 0, 0, 0);
    pix(121, 220, 1, 0, 1, 0);
    EnemyX = 105; EnemyY = 205;
    pix(115, 215, 1, 1, 1, 0);

    for (int i = 0; i < 300; i++) begin
      base = ($urandom_range(0, 3) == 0) ? 980 : 100;
      ShipX  = 10'(base + $urandom_range(0, 40)); ShipY  = 10'(base + $urandom_range(0, 40));
      EnemyX = 10'(base + $urandom_range(0, 40)); EnemyY = 10'(base + $urandom_range(0, 40));
      LaserX = 10'(base + $urandom_range(0, 40)); LaserY = 10'(base + $urandom_range(0, 40));
      EnemyAlive  = 1'($urandom_range(0, 1));
      LaserActive = 1'($urandom_range(0, 1));
      pix(base - 10 + int'($urandom_range(0, 53)), base - 10 + int'($urandom_range(0, 53)),
          $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end

    ShipX = 100; ShipY = 200; LaserActive = 0;
    pix(100, 200, 1, 0, 0, 0);
    pix(101, 200, 1, 0, 0, 0);
    Reset_n = 1'b0;
    #1;
    sb.delete();
    check_reset_outs("mid_reset");
    repeat (3) @(posedge Clk);
    #1;
    check_reset_outs("held_reset");
    Reset_n = 1'b1;
    pix(102, 201, 1, 1, 1, 0);
    pix(139, 239, 1, 0, 1, 0);

    ShipX = 600; ShipY = 0; EnemyX = 300; EnemyY = 300; EnemyAlive = 1; LaserActive = 0;
    fc = 0;
    enemy_check();
    hit_pulse(1);
    for (int k = 0; k < 16; k++) begin
      enemy_check();
      frame_edge();
    end
    enemy_check();
    hit_pulse(1);
    repeat (3) frame_edge();
    enemy_check();
    hit_pulse(1);
    enemy_check();
    frame_edge();
    enemy_check();
    hit_pulse(0);
    enemy_check();
    frame_edge();
    enemy_check();

    repeat (4) @(posedge Clk);
    #1;
    check("sb_drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
